dtree_vote_smoother: RTL and testbench
======================================

Name: dtree_vote_smoother

Overview:
- Sits directly downstream of the combinational decision-tree classifier.
- Collects a window of WIN consecutive per-sample class predictions and emits one smoothed decision per window: the majority class.
- Reduces single-sample misclassification jitter before the result leaves the printed classifier.
- The argmax is computed by a sequential scan, one class per cycle, to keep area small for printed technology.

Parameters:
- NUM_CLASSES, 16, number of valid class indices (0..NUM_CLASSES-1); must be 2..32.
- WIN, 8, valid predictions per voting window; must be 1..255.
- CLS_W, 5, width of class index, matches classifier output width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- in_valid  input  1  in_class carries a prediction this cycle.
- in_class  input  CLS_W  predicted class from the tree.
- in_ready  output  1  block accepts a prediction this cycle.
- out_valid  output  1  one-cycle pulse: out_class/out_votes hold a new window result.
- out_class  output  CLS_W  majority class of the last completed window.
- out_votes  output  clog2(WIN+1)  vote count of out_class.
- err_range  output  1  sticky flag: an out-of-range class was received.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values:
  - State ACCUM; all per-class counters 0; sample counter 0.
  - in_ready=1, out_valid=0, out_class=0, out_votes=0, err_range=0.
- Counters: NUM_CLASSES counters, each clog2(WIN+1) bits, plus a sample counter of the same width. No counter can overflow because at most WIN samples enter per window.
- Handshake: a transfer occurs when in_valid && in_ready. in_ready is combinationally 1 only in ACCUM.
- State ACCUM:
  - On transfer with in_class < NUM_CLASSES: increment counter[in_class] and the sample counter.
  - On transfer with in_class >= NUM_CLASSES: sample dropped, no counter changes, err_range set to 1. err_range stays 1 until rst.
  - When a valid transfer brings the sample count to WIN, go to SCAN on the next edge.
- State SCAN:
  - Lasts exactly NUM_CLASSES cycles; index i = 0..NUM_CLASSES-1, one per cycle.
  - Best register initialised at i=0 to (0, counter[0]).
  - For i>0, update best only when counter[i] > best votes (strict). Ties therefore resolve to the lowest class index.
  - in_ready=0 throughout SCAN; upstream holds its data.
- State DONE (1 cycle):
  - out_valid=1; out_class/out_votes load from the best register and hold until the next DONE.
  - All class counters and the sample counter clear; in_ready=0.
  - Next state is ACCUM.
- Latency: if the WIN-th valid sample is accepted at edge t, out_valid is high in cycle t+NUM_CLASSES+1, and in_ready returns high in cycle t+NUM_CLASSES+2.
- Throughput: one window per WIN accept cycles + NUM_CLASSES + 1 cycles minimum.
- Idle cycles (in_valid=0) in ACCUM do not advance the window. There is no timeout.
- rst asserted in any state, mid-window or mid-scan:
  - Everything returns to reset values on that edge and the partial window is discarded.
  - out_valid is never asserted in the cycle after rst.
- out_valid is never asserted outside DONE; it is never asserted two cycles in a row.

Test Plan:
- Basic majority: WIN=8, NC=16, send 3,3,5,3,7,3,5,3 back-to-back → out_valid one cycle, out_class=3, out_votes=5, exactly 17 cycles after the 8th accept edge.
- Tie-break: send 9,4,9,4,9,4,9,4 → out_class=4, out_votes=4. Then a window of all 15 → out_class=15, out_votes=8, and counters confirmed cleared (no carry-over from the first window).
- Backpressure: hold in_valid=1 continuously across two windows → in_ready=0 for 17 cycles per scan/done. No sample lost or duplicated; two results with correct counts.
- Out-of-range: mix class 20 and 31 into a window of otherwise 8 valid class-2 samples → err_range=1 from the edge after the first bad sample and sticky. Result is out_class=2, out_votes=8 after 10 transfers.
- Bubbles: in_valid toggling 1/0 with classes 1,1,1,0,0,0,0,1 → same result as gapless, out_class=0, out_votes=4 (tie resolves to the lower index).
- Reset mid-operation: assert rst after 5 samples, and separately during SCAN → all outputs at reset values, no out_valid. The next full window of class 6 gives out_class=6, out_votes=8.

Source files
------------

// File: rtl/dtree_vote_smoother.sv
// Majority-vote smoother for decision-tree predictions: counts WIN valid class
// votes, then scans the per-class counters one class per cycle to find the winner.
module dtree_vote_smoother #(
  parameter  int NUM_CLASSES = 16,
  parameter  int WIN         = 8,
  parameter  int CLS_W       = 5,
  localparam int CNT_W       = $clog2(WIN + 1),
  localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CLS_W-1:0] in_class,
  output logic             in_ready,
  output logic             out_valid,
  output logic [CLS_W-1:0] out_class,
  output logic [CNT_W-1:0] out_votes,
  output logic             err_range
);

  typedef enum logic [1:0] {ACCUM, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [NUM_CLASSES];
  logic [CNT_W-1:0]   cnt_d [NUM_CLASSES];
  logic [CNT_W-1:0]   sample_q, sample_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CLS_W-1:0]   best_cls_q, best_cls_d;
  logic [CNT_W-1:0]   best_votes_q, best_votes_d;
  logic [CLS_W-1:0]   out_class_q, out_class_d;
  logic [CNT_W-1:0]   out_votes_q, out_votes_d;
  logic               err_q, err_d;
  logic               in_range;
  logic [CLS_W-1:0]   cand_cls;
  logic [CNT_W-1:0]   cand_votes;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_class = out_class_q;
  assign out_votes = out_votes_q;
  assign err_range = err_q;
  assign in_range  = (int'(in_class) < NUM_CLASSES);

  // Candidate best including the class under scan; strict '>' keeps the lowest index on ties.
  always_comb begin
    cand_cls   = best_cls_q;
    cand_votes = best_votes_q;
    if (idx_q == '0) begin
      cand_cls   = '0;
      cand_votes = cnt_q[0];
    end else if (cnt_q[idx_q] > best_votes_q) begin
      cand_cls   = CLS_W'(idx_q);
      cand_votes = cnt_q[idx_q];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sample_d     = sample_q;
    idx_d        = idx_q;
    best_cls_d   = best_cls_q;
    best_votes_d = best_votes_q;
    out_class_d  = out_class_q;
    out_votes_d  = out_votes_q;
    err_d        = err_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          if (in_range) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
              if (in_class == CLS_W'(i)) cnt_d[i] = cnt_q[i] + 1'b1;
            end
            sample_d = sample_q + 1'b1;
            if (sample_q == CNT_W'(WIN - 1)) begin
              state_d = SCAN;
              idx_d   = '0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SCAN: begin
        best_cls_d   = cand_cls;
        best_votes_d = cand_votes;
        idx_d        = idx_q + 1'b1;
        // Publish on the last scan step so the result is already stable during DONE.
        if (idx_q == IDX_W'(NUM_CLASSES - 1)) begin
          out_class_d = cand_cls;
          out_votes_d = cand_votes;
          idx_d       = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        for (int i = 0; i < NUM_CLASSES; i++) cnt_d[i] = '0;
        sample_d = '0;
        state_d  = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
      sample_q     <= '0;
      idx_q        <= '0;
      best_cls_q   <= '0;
      best_votes_q <= '0;
      out_class_q  <= '0;
      out_votes_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= cnt_d[i];
      sample_q     <= sample_d;
      idx_q        <= idx_d;
      best_cls_q   <= best_cls_d;
      best_votes_q <= best_votes_d;
      out_class_q  <= out_class_d;
      out_votes_q  <= out_votes_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_dtree_vote_smoother.sv
// Scoreboard bench for dtree_vote_smoother: tasks push expected window results,
// a negedge monitor pops and checks them along with latency and stall length.
module tb_dtree_vote_smoother;
  localparam int NC    = 16;
  localparam int WIN   = 8;
  localparam int CLS_W = 5;
  localparam int CNT_W = $clog2(WIN + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [CLS_W-1:0] in_class = '0;
  logic             in_ready;
  logic             out_valid;
  logic [CLS_W-1:0] out_class;
  logic [CNT_W-1:0] out_votes;
  logic             err_range;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int cls; int votes; } exp_t;
  exp_t exp_q[$];
  int   edge_q[$];

  dtree_vote_smoother #(.NUM_CLASSES(NC), .WIN(WIN), .CLS_W(CLS_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_class(in_class),
    .in_ready(in_ready), .out_valid(out_valid), .out_class(out_class),
    .out_votes(out_votes), .err_range(err_range)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: tracks window completions, pops expected results, checks latency and stalls.
  int  mcnt = 0;
  int  run = 0;
  bit  prev_rst = 1'b1;
  bit  prev_ov = 1'b0;
  always @(negedge clk) begin
    if (prev_rst) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_rst_out_valid got=%b want=0", out_valid);
      end
    end
    if (rst) begin
      mcnt = 0;
      run = 0;
      edge_q.delete();
    end else begin
      if (in_valid && in_ready && (int'(in_class) < NC)) begin
        mcnt++;
        if (mcnt == WIN) begin
          edge_q.push_back(cyc + 1);
          mcnt = 0;
        end
      end
      if (!in_ready) run++;
      else if (run > 0) begin
        checks++;
        if (run != NC + 1) begin
          errors++;
          $display("FAIL stall_len got=%0d want=%0d", run, NC + 1);
        end
        run = 0;
      end
      if (out_valid) begin
        exp_t e;
        int   lat;
        checks++;
        if (prev_ov) begin
          errors++;
          $display("FAIL out_valid_twice got=1 want=0");
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got=(%0d,%0d) want=none", out_class, out_votes);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (out_class !== CLS_W'(e.cls) || out_votes !== CNT_W'(e.votes)) begin
            errors++;
            $display("FAIL result got=(%0d,%0d) want=(%0d,%0d)", out_class, out_votes, e.cls, e.votes);
          end else
            $display("result class=%0d votes=%0d", out_class, out_votes);
        end
        checks++;
        if (edge_q.size() == 0) begin
          errors++;
          $display("FAIL latency got=no_window want=%0d", NC + 1);
        end else begin
          lat = cyc - edge_q.pop_front() + 1;
          if (lat != NC + 1) begin
            errors++;
            $display("FAIL latency got=%0d want=%0d", lat, NC + 1);
          end
        end
      end
    end
    prev_rst = rst;
    prev_ov  = out_valid;
  end

  task automatic send(input int c);
    int n = 0;
    in_valid = 1'b1;
    in_class = CLS_W'(c);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got=stalled want=ready");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input int c, input int v);
    exp_t e;
    e.cls = c;
    e.votes = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_results();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL result_timeout got=%0d_pending want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_class !== '0 ||
        out_votes !== '0 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL %s got=rdy%b ov%b cls%0d v%0d err%b want=rdy1 ov0 cls0 v0 err0",
               tag, in_ready, out_valid, out_class, out_votes, err_range);
    end else
      $display("%s reset values ok", tag);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals("reset");
  endtask

  task automatic test_basic();
    int s[8] = '{3, 3, 5, 3, 7, 3, 5, 3};
    push_exp(3, 5);
    foreach (s[i]) send(s[i]);
    wait_results();
  endtask

  task automatic test_tie_and_clear();
    push_exp(4, 4);
    for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 9 : 4);
    push_exp(15, 8);
    for (int i = 0; i < 8; i++) send(15);
    wait_results();
  endtask

  task automatic test_back_to_back();
    int s[16] = '{7, 7, 7, 1, 1, 2, 7, 0, 5, 5, 5, 5, 5, 3, 3, 3};
    push_exp(7, 4);
    push_exp(5, 5);
    foreach (s[i]) send(s[i]);
    wait_results();
  endtask

  task automatic test_bubbles();
    int s[8] = '{1, 1, 1, 0, 0, 0, 0, 1};
    push_exp(0, 4);
    foreach (s[i]) begin
      send(s[i]);
      @(posedge clk);
      #1;
    end
    wait_results();
  endtask

  task automatic test_out_of_range();
    int s[10] = '{2, 2, 20, 2, 2, 31, 2, 2, 2, 2};
    push_exp(2, 8);
    foreach (s[i]) begin
      send(s[i]);
      if (i == 1) begin
        checks++;
        if (err_range !== 1'b0) begin
          errors++;
          $display("FAIL err_early got=%b want=0", err_range);
        end
      end
      if (i == 2) begin
        checks++;
        if (err_range !== 1'b1) begin
          errors++;
          $display("FAIL err_set got=%b want=1", err_range);
        end
      end
    end
    wait_results();
    checks++;
    if (err_range !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got=%b want=1", err_range);
    end else
      $display("err_range sticky ok");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send(1);
    pulse_rst();
    check_reset_vals("rst_mid_window");
    push_exp(6, 8);
    for (int i = 0; i < 8; i++) send(6);
    wait_results();
    for (int i = 0; i < 8; i++) send(9);
    repeat (5) @(posedge clk);
    #1;
    pulse_rst();
    check_reset_vals("rst_mid_scan");
    repeat (25) @(posedge clk);
    #1;
    push_exp(6, 8);
    for (int i = 0; i < 8; i++) send(6);
    wait_results();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie_and_clear();
    test_back_to_back();
    test_bubbles();
    test_out_of_range();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
